// File: rtl/user_input_irq.sv
// Avalon-MM key/switch peripheral: sync, debounce, W1C edge latch, level IRQ.
// Define USER_INPUT_DEBOUNCE_EN for debounce counters; undefined = fast sim path.
module user_input_irq #(
   parameter int NKEYS           = 4,
   parameter int NSW             = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   input  logic [NKEYS-1:0] keys,
   input  logic [NSW-1:0]   switches,
   output logic             irq
);

   localparam int N = NKEYS + NSW;
   localparam logic [31:0] ID = 32'h5549_0001;
   localparam logic [N-1:0] KEY_BITS = {{NSW{1'b0}}, {NKEYS{1'b1}}};

   if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_chk
      $error("CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   logic [NKEYS-1:0] key_s1, key_s2;
   logic [NSW-1:0]   sw_s1, sw_s2;
   logic [N-1:0]     sync_v;
   logic [N-1:0]     stable;
   logic [N-1:0]     edge_set;
   logic [N-1:0]     rise_ok;
   logic [N-1:0]     mask;
   logic [N-1:0]     edge_q;
   logic [N-1:0]     w1c;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= keys;
         key_s2 <= key_s1;
         sw_s1  <= switches;
         sw_s2  <= sw_s1;
      end
   end

   // Internal polarity: 1 = pressed / on
   assign sync_v  = {sw_s2, ~key_s2};
   assign rise_ok = ~KEY_BITS | sync_v;

`ifdef USER_INPUT_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]     primed;
   logic [N-1:0]     sync_q;
   logic [N-1:0]     take;
   logic [N-1:0]     clr;
   logic [CNT_W-1:0] cnt [N];

   // Unprimed bits wait for sync to sit still; primed bits wait on a mismatch
   always_comb begin
      take = '0;
      clr  = '0;
      for (int i = 0; i < N; i++) begin
         if (primed[i]) begin
            clr[i] = (sync_v[i] == stable[i]);
         end else begin
            clr[i] = (sync_v[i] != sync_q[i]);
         end
         take[i] = !clr[i] && (cnt[i] == LAST);
      end
   end

   assign edge_set = take & primed & rise_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         stable <= '0;
         primed <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync_q <= sync_v;
         stable <= (stable & ~take) | (sync_v & take);
         primed <= primed | take;
         for (int i = 0; i < N; i++) begin
            if (clr[i] || take[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   logic primed_all;

   assign edge_set = {N{primed_all}} & (sync_v ^ stable) & rise_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable     <= '0;
         primed_all <= 1'b0;
      end else begin
         stable     <= sync_v;
         primed_all <= 1'b1;
      end
   end
`endif

   assign w1c = (avs_write && avs_address == 2'd2) ?
                avs_writedata[N-1:0] : '0;
   assign unused_wdata = ^avs_writedata[31:N];

   always_comb begin
      rd_mux = '0;
      unique case (avs_address)
         2'd0:    rd_mux[N-1:0] = stable;
         2'd1:    rd_mux[N-1:0] = mask;
         2'd2:    rd_mux[N-1:0] = edge_q;
         default: rd_mux = ID;
      endcase
   end

   // A new edge wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask         <= '0;
         edge_q       <= '0;
         irq          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         edge_q <= (edge_q & ~w1c) | edge_set;
         irq    <= |(edge_q & mask);
         if (avs_write && avs_address == 2'd1) begin
            mask <= avs_writedata[N-1:0];
         end
         if (avs_read) begin
            avs_readdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_user_input_irq.sv
// Scoreboard bench for user_input_irq with a history-based reference model.
// Works with or without USER_INPUT_DEBOUNCE_EN.
module tb_user_input_irq;

   localparam int D = 8;
`ifdef USER_INPUT_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic [3:0]  keys = 4'hF;
   logic [3:0]  switches = 4'h0;
   logic        irq;

   int errors = 0;
   int checks = 0;

   user_input_irq #(
      .NKEYS(4), .NSW(4),
      .DEBOUNCE_CYCLES(D), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .avs_address(avs_address),
      .avs_read(avs_read),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata),
      .keys(keys), .switches(switches),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model state (internal polarity, 1 = pressed / on)
   bit [7:0] p1, p2;
   bit [7:0] m_stable, m_primed, m_edge, m_mask;
   bit       m_irq, m_prim_all;
   bit [7:0] hist[$];
   logic [31:0] exp_q[$];

   task automatic model_reset();
      p1 = 0; p2 = 0;
      m_stable = 0; m_primed = 0;
      m_edge = 0; m_mask = 0;
      m_irq = 0; m_prim_all = 0;
      hist.delete();
      hist.push_back(8'h00);
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0: return {24'h0, m_stable};
         2'd1: return {24'h0, m_mask};
         2'd2: return {24'h0, m_edge};
         default: return 32'h5549_0001;
      endcase
   endfunction

   task automatic model_step(input bit [7:0] pins, input bit wr,
                             input bit [1:0] a, input bit [31:0] wd);
      bit [7:0] v, set, clr;
      bit ok;
      v = p2;
      p2 = p1;
      p1 = pins;
      set = 0;
      if (DB) begin
         hist.push_back(v);
         if (hist.size() > D + 1) void'(hist.pop_front());
         for (int i = 0; i < 8; i++) begin
            if (!m_primed[i]) begin
               // D+1 identical samples: accept silently
               ok = (hist.size() == D + 1);
               for (int k = 0; k < hist.size(); k++)
                  if (hist[k][i] != v[i]) ok = 0;
               if (ok) begin
                  m_primed[i] = 1;
                  m_stable[i] = v[i];
               end
            end else if (hist.size() >= D) begin
               // D samples all disagreeing with stable: accept
               ok = 1;
               for (int k = hist.size() - D; k < hist.size(); k++)
                  if (hist[k][i] == m_stable[i]) ok = 0;
               if (ok) begin
                  if (i >= 4 || v[i]) set[i] = 1;
                  m_stable[i] = v[i];
               end
            end
         end
      end else begin
         for (int i = 0; i < 8; i++)
            if (m_prim_all && v[i] != m_stable[i] && (i >= 4 || v[i]))
               set[i] = 1;
         m_stable = v;
         m_prim_all = 1;
      end
      clr = (wr && a == 2'd2) ? wd[7:0] : 8'h00;
      m_irq = |(m_edge & m_mask);
      m_edge = (m_edge & ~clr) | set;
      if (wr && a == 2'd1) m_mask = wd[7:0];
   endtask

   task automatic tick();
      if (avs_read && !reset) exp_q.push_back(model_read(avs_address));
      @(posedge clk);
      if (reset) model_reset();
      else model_step({switches, ~keys}, avs_write,
                      avs_address, avs_writedata);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input logic [1:0] a);
      avs_read = 1; avs_address = a;
      tick();
      avs_read = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_write = 1; avs_address = a; avs_writedata = d;
      tick();
      avs_write = 0;
   endtask

   // Monitor: readdata one cycle after a read, irq every cycle
   bit rd_seen = 0;
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            rd_seen = 0;
         end else if (rd_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rdata: got %h, no expected entry",
                        avs_readdata);
            end else begin
               e = exp_q.pop_front();
               if (avs_readdata !== e) begin
                  errors++;
                  $display("FAIL rdata: got %h exp %h at %0t",
                           avs_readdata, e, $time);
               end
            end
         end
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq: got %b exp %b at %0t", irq, m_irq, $time);
         end
         rd_seen = avs_read && !reset;
      end
   end

   initial begin
      bit done;
      model_reset();
      idle(3);
      reset = 0;
      idle(12);
      for (int a = 0; a < 4; a++) rd(2'(a));

      // key0 bounce then hold pressed, STATUS polled every cycle
      for (int b = 0; b < 4; b++) begin
         keys[0] = (b % 2 == 0) ? 1'b1 : 1'b0;
         idle(2);
      end
      keys[0] = 1'b0;
      for (int i = 0; i < 14; i++) rd(2'd0);
      rd(2'd2);

      // clear, release (no edge), masked press raises irq, W1C drops it
      wr(2'd2, 32'h01);
      keys[0] = 1'b1;
      idle(14);
      rd(2'd2);
      wr(2'd1, 32'h01);
      keys[0] = 1'b0;
      idle(14);
      rd(2'd2);
      wr(2'd2, 32'h01);
      idle(3);
      rd(2'd2);
      keys[0] = 1'b1;
      idle(14);
      rd(2'd2);

      // switches on through reset
      switches = 4'hF;
      reset = 1;
      model_reset();
      exp_q.delete();
      idle(2);
      reset = 0;
      idle(16);
      rd(2'd0);
      rd(2'd2);
      switches[1] = 1'b0;
      idle(14);
      rd(2'd2);
      wr(2'd2, 32'hFF);

      // key1 edge coincides with W1C of bit 1
      wr(2'd1, 32'h02);
      keys[1] = 1'b0;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         avs_write = 1; avs_address = 2'd2; avs_writedata = 32'h02;
         tick();
         done = m_edge[1];
      end
      avs_write = 0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL set_vs_w1c: key1 edge never seen in 60 cycles");
      end
      idle(3);
      rd(2'd2);
      rd(2'd1);

      // reset in the middle of a debounce
      keys[2] = 1'b0;
      idle(4);
      reset = 1;
      model_reset();
      exp_q.delete();
      idle(2);
      reset = 0;
      idle(16);
      rd(2'd2);
      rd(2'd0);
      keys[2] = 1'b1;
      keys[3] = 1'b0;
      idle(3);
      rd(2'd2);
      idle(12);
      rd(2'd2);

      // randomized traffic and pin activity
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 24) == 0) begin
            int b = $urandom_range(0, 7);
            if (b < 4) keys[b] = ~keys[b];
            else switches[b-4] = ~switches[b-4];
         end
         avs_address   = 2'($urandom_range(0, 3));
         avs_read      = ($urandom_range(0, 2) == 0);
         avs_write     = ($urandom_range(0, 5) == 0);
         avs_writedata = $urandom;
         tick();
      end
      avs_read = 0;
      avs_write = 0;
      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads unanswered", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
